// File: rtl/aes_block_packer.sv
// Byte-stream to 16-byte AES block packer with zero padding and a key register
// that cannot change while a block is waiting for the encryption core.
module aes_block_packer (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0][7:0] key_in,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0][7:0] out_block,
    output logic [15:0][7:0] out_key,
    output logic [4:0]       out_bytes,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int BLOCK_BYTES = 16;

    typedef enum logic [1:0] {
        NOKEY = 2'd0,
        FILL  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [15:0][7:0] buffer;
    logic [15:0][7:0] key_reg;
    logic [4:0]       cnt;
    logic [4:0]       bytes_q;
    logic             last_q;
    logic             key_loaded;

    logic             byte_xfer;
    logic             blk_xfer;
    logic             key_xfer;
    logic             blk_full;

    assign byte_xfer = in_valid && in_ready;
    assign blk_xfer  = out_valid && out_ready;
    assign key_xfer  = key_valid && key_ready;
    assign blk_full  = byte_xfer && (in_last || cnt == 5'(BLOCK_BYTES - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= NOKEY;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs are pure functions of state so the core sees stable
    // ready/valid; key_ready drops in HOLD to freeze the key with the block.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        key_ready = 1'b0;
        unique case (state)
            NOKEY: begin
                key_ready = 1'b1;
                if (key_valid) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                key_ready = 1'b1;
                in_ready  = key_loaded;
                if (in_valid && key_loaded &&
                    (in_last || cnt == 5'(BLOCK_BYTES - 1))) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = FILL;
                end
            end
            default: begin
                state_nxt = NOKEY;
            end
        endcase
    end

    // Buffer is cleared after each block so bytes past cnt are already the padding.
    always_ff @(posedge clk) begin
        if (!rst) begin
            buffer     <= '0;
            cnt        <= '0;
            key_reg    <= '0;
            key_loaded <= 1'b0;
            bytes_q    <= '0;
            last_q     <= 1'b0;
        end else begin
            if (key_xfer) begin
                key_reg    <= key_in;
                key_loaded <= 1'b1;
            end
            if (byte_xfer) begin
                buffer[cnt[3:0]] <= in_data;
                cnt              <= cnt + 5'd1;
                if (blk_full) begin
                    bytes_q <= cnt + 5'd1;
                    last_q  <= in_last;
                end
            end
            if (blk_xfer) begin
                buffer  <= '0;
                cnt     <= '0;
                bytes_q <= '0;
                last_q  <= 1'b0;
            end
        end
    end

    assign out_block = buffer;
    assign out_key   = key_reg;
    assign out_bytes = bytes_q;
    assign out_last  = last_q;

endmodule
